// File: rtl/sga_game_fsm.sv
// Game control unit for the Snake Game Arcade.
// Owns the snake size, the play-tick timer and the lives counter. It sequences
// the datapath through render, wait, move and compare phases. All strobes and
// status flags are Moore outputs, registered from the next-state decode so that
// they line up with the state register.
module sga_game_fsm #(
  parameter int SIZE_W     = 6,
  parameter int INIT_SIZE  = 3,
  parameter int MAX_SIZE   = 36,
  parameter int PLAY_TICKS = 25000000,
  parameter int TICK_W     = 25,
  parameter int LIVES      = 3
) (
  input  logic              clock,
  input  logic              restart_n,
  input  logic              start,
  input  logic              pause,
  input  logic              is_at_apple,
  input  logic              is_at_border,
  input  logic              is_at_body,
  input  logic              render_finish,
  output logic [SIZE_W-1:0] size,
  output logic [2:0]        lives_left,
  output logic              render_clr,
  output logic              render_count,
  output logic              register_apple,
  output logic              reset_apple,
  output logic              snapshot,
  output logic              move,
  output logic              grow,
  output logic              paused,
  output logic              finished,
  output logic              won,
  output logic              lost,
  output logic [4:0]        db_state
);

  typedef enum logic [4:0] {
    IDLE              = 5'd0,
    PREPARA           = 5'd1,
    GERA_MACA_INICIAL = 5'd2,
    RENDERIZA         = 5'd3,
    PROXIMO_RENDER    = 5'd4,
    ESPERA            = 5'd5,
    REGISTRA          = 5'd6,
    MOVE              = 5'd7,
    COMPARA           = 5'd8,
    COMEU_MACA        = 5'd9,
    CRESCE            = 5'd10,
    GERA_MACA         = 5'd11,
    FEZ_NADA          = 5'd12,
    PAUSOU            = 5'd13,
    PERDEU_VIDA       = 5'd14,
    PERDEU            = 5'd15,
    GANHOU            = 5'd16
  } state_e;

  localparam logic [SIZE_W-1:0] INIT_SIZE_C = SIZE_W'(INIT_SIZE);
  localparam logic [SIZE_W-1:0] MAX_SIZE_C  = SIZE_W'(MAX_SIZE);
  localparam logic [SIZE_W-1:0] LAST_SIZE_C = SIZE_W'(MAX_SIZE - 1);
  localparam logic [SIZE_W-1:0] ONE_SIZE_C  = SIZE_W'(1);
  localparam logic [TICK_W-1:0] LAST_TICK_C = TICK_W'(PLAY_TICKS - 1);
  localparam logic [TICK_W-1:0] ONE_TICK_C  = TICK_W'(1);
  localparam logic [TICK_W-1:0] ZERO_TICK_C = TICK_W'(0);
  localparam logic [2:0]        LIVES_C     = 3'(LIVES);

  state_e              state_q, state_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [2:0]          lives_q, lives_d;
  logic [TICK_W-1:0]   play_cnt_q, play_cnt_d;
  logic [10:0]         outs_q, outs_d;
  logic                collide_s;

  // Moore decode of one state into
  // {render_clr, render_count, register_apple, reset_apple, snapshot, move,
  //  grow, paused, finished, won, lost}.
  function automatic logic [10:0] decode_outs(input state_e s);
    logic [10:0] o;
    o = 11'd0;
    case (s)
      GERA_MACA_INICIAL: o = 11'b10100000000;
      GERA_MACA:         o = 11'b10100000000;
      FEZ_NADA:          o = 11'b10000000000;
      PROXIMO_RENDER:    o = 11'b01000000000;
      COMEU_MACA:        o = 11'b00010000000;
      REGISTRA:          o = 11'b00001000000;
      MOVE:              o = 11'b00000100000;
      CRESCE:            o = 11'b00000010000;
      PAUSOU:            o = 11'b00000001000;
      GANHOU:            o = 11'b00000000110;
      PERDEU:            o = 11'b00000000101;
      default:           o = 11'd0;
    endcase
    return o;
  endfunction

  assign collide_s = is_at_border | is_at_body;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = PREPARA;
        else       state_d = IDLE;
      end
      PREPARA:           state_d = GERA_MACA_INICIAL;
      GERA_MACA_INICIAL: state_d = RENDERIZA;
      RENDERIZA: begin
        if (render_finish) state_d = ESPERA;
        else               state_d = PROXIMO_RENDER;
      end
      PROXIMO_RENDER:    state_d = RENDERIZA;
      ESPERA: begin
        if (pause)                           state_d = PAUSOU;
        else if (play_cnt_q == LAST_TICK_C)  state_d = REGISTRA;
        else                                 state_d = ESPERA;
      end
      PAUSOU: begin
        if (start && !pause) state_d = ESPERA;
        else                 state_d = PAUSOU;
      end
      REGISTRA:          state_d = MOVE;
      MOVE:              state_d = COMPARA;
      COMPARA: begin
        // A collision outranks eating an apple on the same move.
        if (collide_s && (lives_q == 3'd1)) state_d = PERDEU;
        else if (collide_s)                 state_d = PERDEU_VIDA;
        else if (is_at_apple)               state_d = COMEU_MACA;
        else                                state_d = FEZ_NADA;
      end
      COMEU_MACA:        state_d = CRESCE;
      CRESCE: begin
        if (size_q == LAST_SIZE_C) state_d = GANHOU;
        else                       state_d = GERA_MACA;
      end
      GERA_MACA:         state_d = RENDERIZA;
      FEZ_NADA:          state_d = RENDERIZA;
      PERDEU_VIDA:       state_d = PREPARA;
      GANHOU, PERDEU: begin
        if (start) state_d = PREPARA;
        else       state_d = state_q;
      end
      default:           state_d = IDLE;
    endcase
  end

  // Datapath counters: size, lives and the play-tick timer.
  always_comb begin
    size_d     = size_q;
    lives_d    = lives_q;
    play_cnt_d = ZERO_TICK_C;
    outs_d     = decode_outs(state_d);

    case (state_q)
      IDLE, PREPARA: size_d = INIT_SIZE_C;
      CRESCE: begin
        if (size_q < MAX_SIZE_C) size_d = size_q + ONE_SIZE_C;
        else                     size_d = size_q;
      end
      default:       size_d = size_q;
    endcase

    case (state_q)
      IDLE, GANHOU, PERDEU: lives_d = LIVES_C;
      PERDEU_VIDA: begin
        if (lives_q > 3'd1) lives_d = lives_q - 3'd1;
        else                lives_d = lives_q;
      end
      default:              lives_d = lives_q;
    endcase

    // The timer saturates on its last tick so a pause taken on the final
    // ESPERA cycle still resumes into a single closing ESPERA cycle.
    case (state_q)
      ESPERA: begin
        if (play_cnt_q == LAST_TICK_C) play_cnt_d = play_cnt_q;
        else                           play_cnt_d = play_cnt_q + ONE_TICK_C;
      end
      PAUSOU:  play_cnt_d = play_cnt_q;
      default: play_cnt_d = ZERO_TICK_C;
    endcase
  end

  // State, counter and output registers; reset returns to an idle, silent unit.
  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      state_q    <= IDLE;
      size_q     <= INIT_SIZE_C;
      lives_q    <= LIVES_C;
      play_cnt_q <= ZERO_TICK_C;
      outs_q     <= 11'd0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      lives_q    <= lives_d;
      play_cnt_q <= play_cnt_d;
      outs_q     <= outs_d;
    end
  end

  assign size       = size_q;
  assign lives_left = lives_q;
  assign db_state   = state_q;
  assign {render_clr, render_count, register_apple, reset_apple, snapshot,
          move, grow, paused, finished, won, lost} = outs_q;

endmodule

// File: tb/tb_sga_game_fsm.sv
// Self-checking bench for sga_game_fsm with a small game configuration.
module tb_sga_game_fsm;
  localparam int SIZE_W     = 6;
  localparam int INIT_SIZE  = 3;
  localparam int MAX_SIZE   = 5;
  localparam int PLAY_TICKS = 4;
  localparam int TICK_W     = 3;
  localparam int LIVES      = 2;

  logic clock = 1'b0;
  logic restart_n, start, pause, is_at_apple, is_at_border, is_at_body, render_finish;
  logic [SIZE_W-1:0] size;
  logic [2:0] lives_left;
  logic render_clr, render_count, register_apple, reset_apple, snapshot, move, grow;
  logic paused, finished, won, lost;
  logic [4:0] db_state;
  logic [10:0] outs_s;

  int errors = 0;
  int checks = 0;
  int prev_s = 0;
  int m_size = INIT_SIZE;
  int m_lives = LIVES;

  typedef struct {
    bit st, pa, ap, bo, bd, rf;
    int exp_s;
  } vec_t;
  vec_t tbl[$];

  sga_game_fsm #(
    .SIZE_W(SIZE_W), .INIT_SIZE(INIT_SIZE), .MAX_SIZE(MAX_SIZE),
    .PLAY_TICKS(PLAY_TICKS), .TICK_W(TICK_W), .LIVES(LIVES)
  ) dut (
    .clock(clock), .restart_n(restart_n), .start(start), .pause(pause),
    .is_at_apple(is_at_apple), .is_at_border(is_at_border), .is_at_body(is_at_body),
    .render_finish(render_finish), .size(size), .lives_left(lives_left),
    .render_clr(render_clr), .render_count(render_count), .register_apple(register_apple),
    .reset_apple(reset_apple), .snapshot(snapshot), .move(move), .grow(grow),
    .paused(paused), .finished(finished), .won(won), .lost(lost), .db_state(db_state)
  );

  always #5 clock = ~clock;

  assign outs_s = {render_clr, render_count, register_apple, reset_apple, snapshot,
                   move, grow, paused, finished, won, lost};

  // Output set of each state code, straight from the state/strobe table.
  function automatic int spec_outs(input int s);
    logic [10:0] o;
    o = 11'd0;
    o[10] = (s == 2) || (s == 11) || (s == 12);
    o[9]  = (s == 4);
    o[8]  = (s == 2) || (s == 11);
    o[7]  = (s == 9);
    o[6]  = (s == 6);
    o[5]  = (s == 7);
    o[4]  = (s == 10);
    o[3]  = (s == 13);
    o[2]  = (s == 15) || (s == 16);
    o[1]  = (s == 16);
    o[0]  = (s == 15);
    return int'(o);
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Advance one clock and compare the DUT against the expected state; size and
  // lives follow from the state the game was in before the edge.
  task automatic cyc(input int exp_s);
    @(posedge clock);
    #1;
    if (prev_s == 0 || prev_s == 1) m_size = INIT_SIZE;
    else if (prev_s == 10 && m_size < MAX_SIZE) m_size = m_size + 1;
    if (prev_s == 0 || prev_s == 15 || prev_s == 16) m_lives = LIVES;
    else if (prev_s == 14 && m_lives > 1) m_lives = m_lives - 1;
    prev_s = exp_s;
    check("db_state", int'(db_state), exp_s);
    check("outputs", int'(outs_s), spec_outs(exp_s));
    check("size", int'(size), m_size);
    check("lives_left", int'(lives_left), m_lives);
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    restart_n = 1'b0;
    #2;
    m_size = INIT_SIZE;
    m_lives = LIVES;
    prev_s = 0;
    check("reset_state", int'(db_state), 0);
    check("reset_outputs", int'(outs_s), 0);
    check("reset_size", int'(size), INIT_SIZE);
    check("reset_lives", int'(lives_left), LIVES);
    @(negedge clock);
    start = 1'b0; pause = 1'b0;
    restart_n = 1'b1;
  endtask

  // From IDLE/GANHOU/PERDEU to the first RENDERIZA of a fresh life.
  task automatic begin_game();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    cyc(3);
  endtask

  task automatic do_pause(input int len);
    pause = 1'b1;
    cyc(13);
    for (int j = 1; j < len; j++) begin
      start = 1'($urandom_range(0, 1));
      cyc(13);
    end
    start = 1'b0; pause = 1'b0;
    cyc(13);
    start = 1'b1;
    cyc(5);
    start = 1'b0;
  endtask

  // One full move starting from an observed RENDERIZA: extra render visits,
  // the play wait (optionally interrupted) and the COMPARA outcome.
  task automatic play_move(input int renders, input int pause_at, input int pause_len,
                           input bit ap, input bit bo, input bit bd);
    render_finish = 1'b0;
    for (int r = 0; r < renders; r++) begin
      cyc(4);
      cyc(3);
    end
    render_finish = 1'b1;
    cyc(5);
    // Each iteration moves from ESPERA visit k to visit k+1.
    for (int k = 1; k < PLAY_TICKS; k++) begin
      if (k == pause_at) do_pause(pause_len);
      else cyc(5);
    end
    cyc(6);
    cyc(7);
    cyc(8);
    is_at_apple = ap; is_at_border = bo; is_at_body = bd;
    if (bo || bd) begin
      if (m_lives == 1) cyc(15);
      else begin
        cyc(14);
        is_at_apple = 1'b0; is_at_border = 1'b0; is_at_body = 1'b0;
        cyc(1); cyc(2); cyc(3);
      end
    end else if (ap) begin
      cyc(9);
      is_at_apple = 1'b0;
      cyc(10);
      if (m_size == MAX_SIZE - 1) cyc(16);
      else begin
        cyc(11); cyc(3);
      end
    end else begin
      cyc(12); cyc(3);
    end
    is_at_apple = 1'b0; is_at_border = 1'b0; is_at_body = 1'b0;
  endtask

  task automatic add(input bit st, input bit pa, input bit ap, input bit bo,
                     input bit bd, input bit rf, input int s);
    vec_t v;
    v.st = st; v.pa = pa; v.ap = ap; v.bo = bo; v.bd = bd; v.rf = rf; v.exp_s = s;
    tbl.push_back(v);
  endtask

  initial begin
    restart_n = 1'b0; start = 1'b0; pause = 1'b0;
    is_at_apple = 1'b0; is_at_border = 1'b0; is_at_body = 1'b0; render_finish = 1'b0;
    reset_pulse();

    // Opening game: start pulse, apple move, three-visit render, plain move.
    add(1,0,0,0,0,1, 1); add(0,0,0,0,0,1, 2); add(0,0,0,0,0,1, 3);
    add(0,0,0,0,0,1, 5); add(0,0,0,0,0,1, 5); add(0,0,0,0,0,1, 5); add(0,0,0,0,0,1, 5);
    add(0,0,0,0,0,1, 6); add(0,0,0,0,0,1, 7); add(0,0,0,0,0,1, 8);
    add(0,0,1,0,0,1, 9); add(0,0,0,0,0,1, 10); add(0,0,0,0,0,1, 11); add(0,0,0,0,0,1, 3);
    add(0,0,0,0,0,0, 4); add(0,0,0,0,0,1, 3); add(0,0,0,0,0,0, 4); add(0,0,0,0,0,1, 3);
    add(0,0,0,0,0,0, 4); add(0,0,0,0,0,1, 3);
    add(0,0,0,0,0,1, 5); add(0,0,0,0,0,1, 5); add(0,0,0,0,0,1, 5); add(0,0,0,0,0,1, 5);
    add(0,0,0,0,0,1, 6); add(0,0,0,0,0,1, 7); add(0,0,0,0,0,1, 8);
    add(0,0,0,0,0,1, 12); add(0,0,0,0,0,1, 3);
    foreach (tbl[i]) begin
      start = tbl[i].st; pause = tbl[i].pa; is_at_apple = tbl[i].ap;
      is_at_border = tbl[i].bo; is_at_body = tbl[i].bd; render_finish = tbl[i].rf;
      cyc(tbl[i].exp_s);
    end
    start = 1'b0; is_at_apple = 1'b0;

    // Pause after two ESPERA cycles; only the remaining two elapse afterwards.
    play_move(0, 2, 6, 1'b0, 1'b0, 1'b0);

    // Pause held from RENDERIZA is ignored there and taken on ESPERA entry;
    // pause held through REGISTRA..FEZ_NADA is ignored.
    render_finish = 1'b1; pause = 1'b1;
    cyc(5);
    cyc(13);
    pause = 1'b0; start = 1'b1;
    cyc(5);
    start = 1'b0;
    for (int k = 2; k < PLAY_TICKS; k++) cyc(5);
    cyc(6);
    pause = 1'b1;
    cyc(7); cyc(8); cyc(12); cyc(3);
    pause = 1'b0;

    // Second apple reaches MAX_SIZE: win, hold, then restart.
    play_move(0, 0, 0, 1'b1, 1'b0, 1'b0);
    check("win_reached", prev_s, 16);
    cyc(16); cyc(16);
    begin_game();

    // Grow, lose a life on the body (size reloads), then lose the game on the border.
    play_move(0, 0, 0, 1'b1, 1'b0, 1'b0);
    play_move(0, 0, 0, 1'b0, 1'b0, 1'b1);
    play_move(1, 0, 0, 1'b0, 1'b1, 1'b0);
    check("game_lost", prev_s, 15);
    cyc(15);
    begin_game();

    // Apple and border together on the last life: collision wins.
    play_move(0, 0, 0, 1'b0, 1'b0, 1'b1);
    play_move(0, 0, 0, 1'b1, 1'b1, 1'b0);
    check("collision_priority", prev_s, 15);
    begin_game();

    // Asynchronous reset in the middle of ESPERA, with pause requested.
    render_finish = 1'b1;
    cyc(5); cyc(5);
    pause = 1'b1;
    reset_pulse();
    begin_game();

    // Randomised play against the move-level model.
    for (int n = 0; n < 60; n++) begin
      int pat, plen, ren;
      bit ap, bo, bd;
      ren  = int'($urandom_range(0, 2));
      pat  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, PLAY_TICKS - 1)) : 0;
      plen = int'($urandom_range(1, 4));
      ap   = ($urandom_range(0, 2) == 0);
      bo   = ($urandom_range(0, 7) == 0);
      bd   = ($urandom_range(0, 7) == 0);
      play_move(ren, pat, plen, ap, bo, bd);
      if (prev_s == 15 || prev_s == 16) begin
        for (int h = 0; h < int'($urandom_range(0, 2)); h++) cyc(prev_s);
        begin_game();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sga_game_fsm.md
# sga_game_fsm

Parametrised game control unit for the Snake Game Arcade. It replaces the fixed-size control FSM with one that owns the snake-size counter, the play-tick timer and a lives counter. It adds the growth, collision-loss, win-on-max-size and multi-life paths. It sits between the input/pace logic and the datapath (apple register, body memory, render counter), and drives all datapath strobes as Moore outputs.

## Interface
- SIZE_W, 6: width of `size` and of the size arithmetic.
- INIT_SIZE, 3: snake length loaded at the start of each life.
- MAX_SIZE, 36: length at which the game is won; must satisfy INIT_SIZE < MAX_SIZE ≤ 2^SIZE_W − 1.
- PLAY_TICKS, 25000000: clock cycles spent in ESPERA per move; ≥ 1.
- TICK_W, 25: play timer width; 2^TICK_W ≥ PLAY_TICKS.
- LIVES, 3: lives per game, 1..7.

Ports:
- clock  in  1  system clock, rising edge.
- restart_n  in  1  asynchronous, active-low reset.
- start  in  1  level; starts the game, resumes from pause, restarts from GANHOU/PERDEU.
- pause  in  1  level; request to pause.
- is_at_apple  in  1  head on apple (valid in COMPARA).
- is_at_border  in  1  head outside field (valid in COMPARA).
- is_at_body  in  1  head on body (valid in COMPARA).
- render_finish  in  1  last segment rendered (valid in RENDERIZA).
- size  out  SIZE_W  current snake length.
- lives_left  out  3  remaining lives.
- render_clr, render_count, register_apple, reset_apple, snapshot, move, grow  out  1 each  datapath strobes.
- paused, finished, won, lost  out  1 each  status.
- db_state  out  5  state code.

## Operation
States (db_state code): IDLE 0, PREPARA 1, GERA_MACA_INICIAL 2, RENDERIZA 3, PROXIMO_RENDER 4, ESPERA 5, REGISTRA 6, MOVE 7, COMPARA 8, COMEU_MACA 9, CRESCE 10, GERA_MACA 11, FEZ_NADA 12, PAUSOU 13, PERDEU_VIDA 14, PERDEU 15, GANHOU 16.

Transitions:
- IDLE → PREPARA if start.
- PREPARA → GERA_MACA_INICIAL → RENDERIZA.
- RENDERIZA → ESPERA if render_finish, else PROXIMO_RENDER. PROXIMO_RENDER → RENDERIZA.
- ESPERA: pause → PAUSOU (pause has priority). Otherwise play_cnt == PLAY_TICKS−1 → REGISTRA. Otherwise stay.
- PAUSOU → ESPERA if start and !pause.
- REGISTRA → MOVE → COMPARA.
- COMPARA, in priority order:
  - (is_at_border | is_at_body) with lives_left == 1 → PERDEU.
  - (is_at_border | is_at_body) otherwise → PERDEU_VIDA.
  - is_at_apple → COMEU_MACA.
  - otherwise → FEZ_NADA.
- COMEU_MACA → CRESCE. CRESCE → GANHOU if size == MAX_SIZE−1 (pre-increment value), else GERA_MACA.
- GERA_MACA → RENDERIZA. FEZ_NADA → RENDERIZA. PERDEU_VIDA → PREPARA.
- GANHOU / PERDEU → PREPARA if start.
- Unused codes → IDLE.

Outputs (Moore, decoded from state only):
- render_clr: GERA_MACA_INICIAL, GERA_MACA, FEZ_NADA.
- render_count: PROXIMO_RENDER.
- register_apple: GERA_MACA_INICIAL, GERA_MACA.
- reset_apple: COMEU_MACA.
- snapshot: REGISTRA.
- move: MOVE.
- grow: CRESCE.
- paused: PAUSOU.
- won: GANHOU. lost: PERDEU. finished = won | lost.

Registers, all updated on the clock edge:
- size: loads INIT_SIZE in IDLE and PREPARA; increments by 1 in CRESCE, saturating at MAX_SIZE.
- lives_left: loads LIVES in IDLE, GANHOU and PERDEU; decrements in PERDEU_VIDA, never below 1.
- play_cnt: increments in ESPERA; holds in PAUSOU; clears in every other state.

## Timing
- Reset (restart_n low, asynchronous): state IDLE, size = INIT_SIZE, lives_left = LIVES, play_cnt = 0. All strobe and status outputs are 0; db_state = 0.
- Reset asserted mid-game wins over every other event, including pause.
- start is sampled on each rising edge. IDLE with start high reaches PREPARA one cycle later.
- ESPERA lasts exactly PLAY_TICKS cycles when no pause occurs. Pausing preserves play_cnt, so after resume only the remaining cycles elapse.
- pause is ignored outside ESPERA. A pause held high is taken on the next ESPERA entry.
- Apple move, COMPARA to first RENDERIZA: 4 cycles. No-apple move: 2 cycles.
- Each strobe is high for exactly one cycle per state visit.
- Every state visit is one cycle, except IDLE, ESPERA, PAUSOU, GANHOU and PERDEU, which wait.
- Border/body and apple high together: collision wins.

## Test plan
- Reset, then start held for one cycle with PLAY_TICKS = 4 and render_finish = 1 → db_state sequence 0,1,2,3,5,5,5,5,6,7,8. register_apple is high in state 2.
- render_finish low for 3 RENDERIZA visits → render_count pulses 3 times, then ESPERA.
- PLAY_TICKS = 10, pause high after 4 ESPERA cycles for 20 cycles, then start → PAUSOU held with play_cnt = 4. After resume, exactly 6 more ESPERA cycles before REGISTRA.
- INIT_SIZE = 3, MAX_SIZE = 5, is_at_apple on two moves → size goes 3→4→5; second CRESCE → GANHOU, won = finished = 1. start → PREPARA with size = 3, lives = LIVES.
- LIVES = 2, is_at_body on a move → PERDEU_VIDA, lives 2→1, size reloaded. Next is_at_border → PERDEU, lost = 1, lives_left reloads to 2.
- is_at_apple and is_at_border together in COMPARA, lives = 1 → PERDEU with reset_apple never asserted. restart_n pulsed low in ESPERA → immediate IDLE with all outputs 0.
